// File: rtl/clock_time_setter_pkg.sv
// Shared types, digit limits and the per-digit validation rule for the oven clock setter.
// The CLOCK_SET_12H_EN build only changes which branch of digit_ok the top selects.
package oven_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    LOAD
  } set_state_t;

  localparam bcd_t DIGIT_MAX        = 4'd9;
  localparam bcd_t HR_MSB_MAX_24    = 4'd2;
  localparam bcd_t HR_LSB_MAX_AT_20 = 4'd3;
  localparam bcd_t MIN_MSB_MAX      = 4'd5;
  localparam bcd_t HR_MSB_MAX_12    = 4'd1;
  localparam bcd_t HR_LSB_MAX_AT_10 = 4'd2;

  // hr2 is the hours MSB already entered; it bounds the hours LSB.
  function automatic logic digit_ok(input logic [1:0] idx, input bcd_t d,
                                    input bcd_t hr2, input logic twelve_hr);
    logic ok;
    ok = 1'b0;
    if (d <= DIGIT_MAX) begin
      case (idx)
        2'd3: ok = twelve_hr ? (d <= HR_MSB_MAX_12) : (d <= HR_MSB_MAX_24);
        2'd2: begin
          if (twelve_hr)
            ok = (hr2 == 4'd1) ? (d <= HR_LSB_MAX_AT_10) : (d != 4'd0);
          else
            ok = (hr2 == HR_MSB_MAX_24) ? (d <= HR_LSB_MAX_AT_20) : 1'b1;
        end
        2'd1:    ok = (d <= MIN_MSB_MAX);
        default: ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/clock_time_setter_if.sv
// Load handshake between the time setter (master) and the clock counter (slave).
interface clock_time_setter_if;
  import oven_pkg::*;

  logic load_valid;
  logic load_ready;
  bcd_t set_min1;
  bcd_t set_min2;
  bcd_t set_hr1;
  bcd_t set_hr2;

  modport master (output load_valid, output set_min1, output set_min2,
                  output set_hr1, output set_hr2, input load_ready);
  modport slave  (input load_valid, input set_min1, input set_min2,
                  input set_hr1, input set_hr2, output load_ready);
endinterface

// File: rtl/clock_time_setter_button_debounce.sv
// Synchroniser plus stability counter for one active-low key; emits a one-cycle
// press pulse when the debounced level falls.
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin_n,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_press;
  logic                   w_sync;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign o_press = r_press;

  // Keys idle high, so the chain and the debounced level reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin_n};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
    end else if (w_sync == r_stable) begin
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= w_sync;
      r_press  <= ~w_sync;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_press <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// Time-of-day entry FSM: debounced keys, shadow digits, validation, display mux and load handshake.
// Define CLOCK_SET_12H_EN for 12-hour validation; ports are identical in both builds.
module clock_time_setter
  import oven_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  bcd_t                in,
  input  logic [1:0]          pushButton,
  input  bcd_t                cur_min1,
  input  bcd_t                cur_min2,
  input  bcd_t                cur_hr1,
  input  bcd_t                cur_hr2,
  clock_time_setter_if.master load_bus,
  output bcd_t                disp0,
  output bcd_t                disp1,
  output bcd_t                disp2,
  output bcd_t                disp3,
  output logic                edit_active,
  output logic [1:0]          digit_idx,
  output logic                error
);

  set_state_t       r_state, w_state_next;
  bcd_t       [3:0] r_shadow, w_shadow_next;
  bcd_t       [3:0] r_set, w_set_next;
  logic       [1:0] r_idx, w_idx_next;
  logic             r_valid, w_valid_next;
  logic             r_error, w_error_next;
  logic             w_enter_ev, w_cancel_ev, w_enter, w_digit_ok;
  bcd_t       [1:0] w_entry_hr;

  button_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .reset(reset), .i_pin_n(pushButton[0]), .o_press(w_enter_ev));
  button_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clk(clk), .reset(reset), .i_pin_n(pushButton[1]), .o_press(w_cancel_ev));

  assign w_enter = w_enter_ev & ~w_cancel_ev;

`ifdef CLOCK_SET_12H_EN
  localparam logic TWELVE_HR = 1'b1;
  logic w_hr_bad;
  // A running hour outside 01-12 cannot be edited digit by digit, so start from 12.
  assign w_hr_bad   = (cur_hr2 > 4'd1) || (cur_hr1 > 4'd9) ||
                      ((cur_hr2 == 4'd1) && (cur_hr1 > 4'd2)) ||
                      ((cur_hr2 == 4'd0) && (cur_hr1 == 4'd0));
  assign w_entry_hr = w_hr_bad ? {4'd1, 4'd2} : {cur_hr2, cur_hr1};
`else
  localparam logic TWELVE_HR = 1'b0;
  assign w_entry_hr = {cur_hr2, cur_hr1};
`endif

  assign w_digit_ok = digit_ok(r_idx, in, r_shadow[3], TWELVE_HR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_set    <= '0;
      r_idx    <= 2'd3;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shadow <= w_shadow_next;
      r_set    <= w_set_next;
      r_idx    <= w_idx_next;
      r_valid  <= w_valid_next;
      r_error  <= w_error_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_shadow_next = r_shadow;
    w_set_next    = r_set;
    w_idx_next    = r_idx;
    w_valid_next  = r_valid;
    w_error_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_enter) begin
          w_shadow_next = {w_entry_hr, cur_min2, cur_min1};
          w_idx_next    = 2'd3;
          w_state_next  = ENTRY;
        end
      end
      ENTRY: begin
        if (w_cancel_ev) begin
          w_idx_next   = 2'd3;
          w_state_next = IDLE;
        end else if (w_enter) begin
          if (w_digit_ok) begin
            w_shadow_next[r_idx] = in;
            if (r_idx != 2'd0) begin
              w_idx_next = r_idx - 2'd1;
            end else begin
              w_set_next   = w_shadow_next;
              w_valid_next = 1'b1;
              w_state_next = LOAD;
            end
          end else begin
            w_error_next = 1'b1;
          end
        end
      end
      LOAD: begin
        if (load_bus.load_ready) begin
          w_valid_next = 1'b0;
          w_idx_next   = 2'd3;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign load_bus.load_valid = r_valid;
  assign load_bus.set_min1   = r_set[0];
  assign load_bus.set_min2   = r_set[1];
  assign load_bus.set_hr1    = r_set[2];
  assign load_bus.set_hr2    = r_set[3];

  assign disp0 = (r_state == IDLE) ? cur_min1 : r_shadow[0];
  assign disp1 = (r_state == IDLE) ? cur_min2 : r_shadow[1];
  assign disp2 = (r_state == IDLE) ? cur_hr1  : r_shadow[2];
  assign disp3 = (r_state == IDLE) ? cur_hr2  : r_shadow[3];

  assign edit_active = (r_state != IDLE);
  assign digit_idx   = r_idx;
  assign error       = r_error;

endmodule
